// File: rtl/uart_cmd_wrapper_if.sv
// rtl/uart_cmd_wrapper_if.sv - command/response handshake between the UART wrapper and cmd_proc
interface uart_cmd_wrapper_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  modport master (input cmd, cmd_rdy, tx_done, output clr_cmd_rdy, resp, trmt);
  modport slave  (output cmd, cmd_rdy, tx_done, input clr_cmd_rdy, resp, trmt);
endinterface

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - 8N1 UART receiver/transmitter with high/low byte pairing into 16-bit commands
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 5208
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX,
  output logic               TX,
  uart_cmd_wrapper_if.slave  bus
);

  localparam int             CW   = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0]  DIV  = CW'(BAUD_DIV);
  localparam logic [CW-1:0]  HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic          rx_ff1, rx_ff2, rx_prev;
  logic          rx_busy, rx_rdy, rx_ferr;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx;
  logic [7:0]    rx_data;
  logic          start_det;

  assign start_det = !rx_busy && rx_prev && !rx_ff2;

  // Sample index 0 is the start bit, 1..8 data, 9 stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
      rx_rdy  <= 1'b0;
      rx_ferr <= 1'b0;
      if (start_det) begin
        rx_busy <= 1'b1;
        rx_cnt  <= HALF;
        rx_idx  <= '0;
      end else if (rx_busy) begin
        if (rx_cnt == ONE) begin
          rx_cnt <= DIV;
          rx_idx <= rx_idx + 4'd1;
          if (rx_idx == 4'd9) begin
            rx_busy <= 1'b0;
            rx_rdy  <= rx_ff2;
            rx_ferr <= !rx_ff2;
          end else if (rx_idx != 4'd0) begin
            rx_data <= {rx_ff2, rx_data[7:1]};
          end
        end else begin
          rx_cnt <= rx_cnt - ONE;
        end
      end
    end
  end

  typedef enum logic {HIGH, LOW} pair_state_t;
  pair_state_t state, state_nxt;
  logic        load_high, load_cmd;
  logic [7:0]  high_reg;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HIGH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_high = 1'b0;
    load_cmd  = 1'b0;
    if (rx_ferr) begin
      state_nxt = HIGH;
    end else if (rx_rdy) begin
      case (state)
        HIGH: begin
          load_high = 1'b1;
          state_nxt = LOW;
        end
        LOW: begin
          load_cmd  = 1'b1;
          state_nxt = HIGH;
        end
        default: state_nxt = HIGH;
      endcase
    end
  end

  // A completing pair takes priority over the consumer's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_reg  <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      if (load_high) high_reg <= rx_data;
      if (load_cmd)  cmd_q    <= {high_reg, rx_data};
      if (load_cmd)                        cmd_rdy_q <= 1'b1;
      else if (load_high || bus.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
    end
  end

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;

  logic          tx_busy, tx_q, tx_done_q;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_left;
  logic [8:0]    tx_shift;

  // Start bit goes out on the accepting edge; stop bit sits in tx_shift[8].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy   <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
      tx_cnt    <= '0;
      tx_left   <= '0;
      tx_shift  <= '1;
    end else if (bus.trmt && !tx_busy) begin
      tx_busy   <= 1'b1;
      tx_q      <= 1'b0;
      tx_done_q <= 1'b0;
      tx_cnt    <= DIV - ONE;
      tx_left   <= 4'd9;
      tx_shift  <= {1'b1, bus.resp};
    end else if (tx_busy) begin
      if (tx_cnt == '0) begin
        if (tx_left == 4'd0) begin
          tx_busy   <= 1'b0;
          tx_done_q <= 1'b1;
        end else begin
          tx_q     <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_left  <= tx_left - 4'd1;
          tx_cnt   <= DIV - ONE;
        end
      end else begin
        tx_cnt <= tx_cnt - ONE;
      end
    end
  end

  assign TX          = tx_q;
  assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - directed self-checking bench for uart_cmd_wrapper
module tb_uart_cmd_wrapper;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_line;
  logic tx_line;
  int   checks = 0;
  int   errors = 0;
  int   rdy_rises = 0;
  int   tx_lows = 0;
  logic rdy_prev = 1'b0;
  int   base_rises, base_lows;
  bit   seen;

  uart_cmd_wrapper_if u_if ();

  uart_cmd_wrapper #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx_line),
    .TX    (tx_line),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.cmd_rdy && !rdy_prev) rdy_rises++;
    rdy_prev = u_if.cmd_rdy;
    if (tx_line == 1'b0) tx_lows++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_line = bits[i];
      repeat (BD) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk) u_if.clr_cmd_rdy = 1'b1;
    @(negedge clk) u_if.clr_cmd_rdy = 1'b0;
  endtask

  task automatic check_tx_frame(input logic [7:0] b, input bit inject);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    @(negedge clk);
    u_if.resp = b;
    u_if.trmt = 1'b1;
    @(negedge clk);
    u_if.trmt = 1'b0;
    repeat (BD / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("tx_bit", 16'(tx_line), 16'(frame[i]));
      if (i < 9) begin
        if (inject && i == 3) begin
          u_if.resp = 8'hFF;
          u_if.trmt = 1'b1;
          @(negedge clk);
          u_if.trmt = 1'b0;
          repeat (BD - 1) @(negedge clk);
        end else begin
          repeat (BD) @(negedge clk);
        end
      end
    end
    check("tx_done_mid_stop", 16'(u_if.tx_done), 16'd0);
    for (int k = 0; k < 20 && !u_if.tx_done; k++) @(negedge clk);
    check("tx_done_end", 16'(u_if.tx_done), 16'd1);
  endtask

  initial begin
    rst_n            = 1'b0;
    rx_line          = 1'b1;
    u_if.trmt        = 1'b0;
    u_if.clr_cmd_rdy = 1'b0;
    u_if.resp        = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", 16'(tx_line), 16'd1);
    check("reset_cmd", u_if.cmd, 16'h0000);
    check("reset_cmd_rdy", 16'(u_if.cmd_rdy), 16'd0);
    check("reset_tx_done", 16'(u_if.tx_done), 16'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_byte(8'h60, 1'b1);
    send_byte(8'h33, 1'b1);
    check("pair1_rdy", 16'(u_if.cmd_rdy), 16'd1);
    check("pair1_cmd", u_if.cmd, 16'h6033);

    send_byte(8'h20, 1'b1);
    check("high_clears_rdy", 16'(u_if.cmd_rdy), 16'd0);
    check("cmd_held", u_if.cmd, 16'h6033);
    send_byte(8'h00, 1'b1);
    check("pair2_rdy", 16'(u_if.cmd_rdy), 16'd1);
    check("pair2_cmd", u_if.cmd, 16'h2000);
    clr_pulse();
    check("clr_rdy", 16'(u_if.cmd_rdy), 16'd0);
    check("clr_cmd_kept", u_if.cmd, 16'h2000);

    check_tx_frame(8'hA5, 1'b1);

    send_byte(8'h77, 1'b0);
    send_byte(8'h40, 1'b1);
    check("ferr_high_rdy", 16'(u_if.cmd_rdy), 16'd0);
    send_byte(8'h12, 1'b1);
    check("ferr_pair_cmd", u_if.cmd, 16'h4012);
    check("ferr_pair_rdy", 16'(u_if.cmd_rdy), 16'd1);
    clr_pulse();

    base_lows = tx_lows;
    send_byte(8'h60, 1'b1);
    rx_line = 1'b0;
    repeat (40) @(negedge clk);
    rst_n   = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_cmd", u_if.cmd, 16'h0000);
    check("midrst_rdy", 16'(u_if.cmd_rdy), 16'd0);
    base_rises = rdy_rises;
    send_byte(8'h50, 1'b1);
    check("midrst_high_rdy", 16'(u_if.cmd_rdy), 16'd0);
    send_byte(8'h07, 1'b1);
    check("midrst_cmd_pair", u_if.cmd, 16'h5007);
    check("midrst_rdy_once", 16'(rdy_rises - base_rises), 16'd1);
    check("midrst_tx_idle", 16'(tx_lows - base_lows), 16'd0);

    send_byte(8'h9C, 1'b1);
    seen = 1'b0;
    fork
      send_byte(8'h0E, 1'b1);
      begin
        u_if.clr_cmd_rdy = 1'b1;
        for (int k = 0; k < 200 && !seen; k++) begin
          @(negedge clk);
          if (u_if.cmd_rdy) seen = 1'b1;
        end
        u_if.clr_cmd_rdy = 1'b0;
      end
    join
    check("set_beats_clr", 16'(seen), 16'd1);
    check("set_beats_clr_cmd", u_if.cmd, 16'h9C0E);
    clr_pulse();

    fork
      begin
        send_byte(8'h3C, 1'b1);
        send_byte(8'h5A, 1'b1);
      end
      check_tx_frame(8'h96, 1'b0);
    join
    check("duplex_cmd", u_if.cmd, 16'h3C5A);
    check("duplex_rdy", 16'(u_if.cmd_rdy), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Knight-side end of the RemoteComm link.
- Receives 8N1 UART bytes on RX, high byte first, and assembles them into a 16-bit command for the command processor.
- Returns 8-bit responses (ack 8'hA5 and similar) on TX.
- Contains its own UART receiver, UART transmitter and byte-pairing FSM; instantiated in KnightsTour between the RX/TX pins and cmd_proc.

Parameters:
BAUD_DIV, 5208, clocks per bit (50 MHz / 9600 baud); benches use 16.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial in from remote, idles high
TX  output  1  serial out to remote, idles high
cmd  output  16  assembled command {first byte, second byte}
cmd_rdy  output  1  new command valid
clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy
resp  input  8  response byte to send
trmt  input  1  one-cycle pulse: start sending resp
tx_done  output  1  response fully shifted out

Behaviour:
- Reset: clk single domain; reset is asynchronous, active-low (rst_n); all flops clear asynchronously.
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_done=0, RX synchronizer flops preset to 1, FSM in HIGH.
- RX path: double-flop synchronizer. Start detected on synchronized 1->0 with receiver idle.
- Receiver counting: baud counter loads BAUD_DIV/2 on start detect (samples at bit centre), then BAUD_DIV per bit.
- Receiver frame: 10 samples (start, 8 data LSB first, stop). rx_rdy pulses one clock after the stop sample.
- Framing error (stop sample = 0): byte discarded, no rx_rdy, pairing FSM forced to HIGH.
- Pairing FSM HIGH: on rx_rdy, latch byte into high register, clear cmd_rdy, go LOW.
- Pairing FSM LOW: on rx_rdy, cmd <= {high_reg, byte}, set cmd_rdy the same edge, go HIGH.
- cmd holds its value until the next complete pair; it never shows a half-updated value.
- cmd_rdy stays set until clr_cmd_rdy is asserted or the next high byte completes.
- Set and clr_cmd_rdy in the same cycle: set wins.
- TX path: trmt while idle latches resp and clears tx_done. Frame is start 0, data LSB first, stop 1, each BAUD_DIV clocks.
- tx_done sets in the cycle the stop bit period ends and stays set until the next accepted trmt.
- trmt while transmitting is ignored; the current frame is not corrupted.
- TX is a registered output; glitch-free.
- RX and TX operate fully concurrently (full duplex).
- Reset asserted mid-frame: both paths abort immediately. TX returns high, a partial high byte is lost, FSM returns to HIGH.

Test Plan:
- BAUD_DIV=16. Send bytes 8'h60, 8'h33 -> cmd_rdy rises within 2 clocks after the 2nd stop-bit sample, cmd=16'h6033. Pulse clr_cmd_rdy -> cmd_rdy=0, cmd still 16'h6033.
- Send 8'h20 then 8'h00 without clearing -> cmd_rdy drops when 8'h20 completes, rises again with cmd=16'h2000.
- Pulse trmt with resp=8'hA5 -> TX shows 0,1,0,1,0,0,1,0,1,1, each 16 clocks. tx_done=1 at frame end. Second trmt mid-frame has no effect.
- Send a framing-error byte (stop=0), then 8'h40, 8'h12 -> cmd=16'h4012; the bad byte is never paired.
- Send byte 8'h60, assert rst_n low for 3 clocks mid-way through the next byte, then send 8'h50, 8'h07 -> cmd=16'h5007, cmd_rdy set once, TX stayed 1.
- Simultaneous completion of the low byte with clr_cmd_rdy high -> cmd_rdy=1. Full duplex: TX frame runs during an RX pair with both results correct.
